mem_phase_seq: RTL and testbench

MEM_PHASE_SEQ -- requirements
Module: mem_phase_seq

---
 rtl/mem_phase_seq_pkg.sv | 13 +
 rtl/mem_phase_seq_phase_counter.sv | 42 ++++
 rtl/mem_phase_seq.sv | 155 +++++++++++++++
 tb/tb_mem_phase_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_phase_seq_pkg.sv
// Shared types for the memory phase sequencer: FSM state encoding and ratio ceiling.
// Pure declarations, no logic; imported by mem_phase_seq and phase_counter.
package BasicTypes;

  localparam int PHASE_SEQ_MAX_RATIO = 16;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } PhaseSeqState;

endpackage

// File: rtl/mem_phase_seq_phase_counter.sv
// Frame phase counter: counts 0..RATIO-1 while enabled, parks on the last phase until memRdy.
// Registered phase, phaseNext is the combinational look-ahead; no handshake of its own.
module phase_counter
  import BasicTypes::*;
#(
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     memRdy,
  output logic [$clog2(RATIO)-1:0] phase,
  output logic [$clog2(RATIO)-1:0] phaseNext,
  output logic                     atLast
);

  localparam int PW = $clog2(RATIO);
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

  assign atLast = (phase == LAST);

  // The last phase is the only point where the memory may stretch the frame.
  always_comb begin
    phaseNext = phase;
    if (enable) begin
      if (!atLast) begin
        phaseNext = phase + 1'b1;
      end else if (memRdy) begin
        phaseNext = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else begin
      phase <= phaseNext;
    end
  end

endmodule

// File: rtl/mem_phase_seq.sv
// Derives a CPU clock/enable and phase-aligned write strobes from the fast memory clock; 0-cycle strobe latency.
// memRdy low at the last phase stretches the frame (HOLD); MEM_PHASE_SEQ_STATS_EN adds frameCnt/stallCnt.
module mem_phase_seq
  import BasicTypes::*;
#(
  parameter int RATIO     = 4,
  parameter int NUM_PORTS = 2,
  parameter int WR_PHASE  = RATIO / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     weReq,
  input  logic                     memRdy,
  output logic                     cpuClk,
  output logic                     cpuClkEn,
  output logic [NUM_PORTS-1:0]     weOut,
  output logic [$clog2(RATIO)-1:0] phase,
  output logic                     stalled
`ifdef MEM_PHASE_SEQ_STATS_EN
  ,
  output logic [31:0]              frameCnt,
  output logic [31:0]              stallCnt
`endif
);

  localparam int PW = $clog2(RATIO);
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);
  localparam logic [PW-1:0] HALF = PW'(RATIO / 2);
  localparam logic [PW-1:0] WRP  = PW'(WR_PHASE);

  if (RATIO < 2 || RATIO > PHASE_SEQ_MAX_RATIO || (RATIO % 2) != 0) begin : gBadRatio
    $error("mem_phase_seq: RATIO must be even and within 2..%0d", PHASE_SEQ_MAX_RATIO);
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : gBadPorts
    $error("mem_phase_seq: NUM_PORTS must be within 1..4");
  end
  if (WR_PHASE < 1 || WR_PHASE > RATIO - 1) begin : gBadWrPhase
    $error("mem_phase_seq: WR_PHASE must be within 1..RATIO-1");
  end

  // Reset asserts asynchronously but releases two clocks later, aligned to clk.
  logic rstMeta;
  logic rstSync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstMeta <= 1'b0;
      rstSync <= 1'b0;
    end else begin
      rstMeta <= 1'b1;
      rstSync <= rstMeta;
    end
  end

  PhaseSeqState  state;
  PhaseSeqState  stateNext;
  logic [PW-1:0] warmCnt;
  logic [PW-1:0] phaseNext;
  logic          atLast;
  logic          cntEnable;

  phase_counter #(
    .RATIO(RATIO)
  ) uPhase (
    .clk      (clk),
    .rst      (rstSync),
    .enable   (cntEnable),
    .memRdy   (memRdy),
    .phase    (phase),
    .phaseNext(phaseNext),
    .atLast   (atLast)
  );

  always_ff @(posedge clk or negedge rstSync) begin
    if (!rstSync) begin
      state <= WARMUP;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rstSync) begin
    if (!rstSync) begin
      warmCnt <= '0;
    end else if (state == WARMUP) begin
      warmCnt <= warmCnt + 1'b1;
    end
  end

  // Strobes and the enable are decoded from the registered state, so a reset clears them at once.
  always_comb begin
    stateNext = state;
    cntEnable = 1'b0;
    cpuClkEn  = 1'b0;
    weOut     = '0;
    stalled   = 1'b0;
    unique case (state)
      WARMUP: begin
        if (warmCnt == LAST) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        cntEnable = 1'b1;
        if (phase == WRP) begin
          weOut = weReq;
        end
        if (atLast) begin
          if (memRdy) begin
            cpuClkEn = 1'b1;
          end else begin
            stateNext = HOLD;
          end
        end
      end
      HOLD: begin
        cntEnable = 1'b1;
        stalled   = 1'b1;
        if (memRdy) begin
          cpuClkEn  = 1'b1;
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = WARMUP;
      end
    endcase
  end

  // cpuClk is a flop fed from the look-ahead phase, so it lines up with phase and never glitches.
  always_ff @(posedge clk or negedge rstSync) begin
    if (!rstSync) begin
      cpuClk <= 1'b1;
    end else begin
      cpuClk <= (phaseNext < HALF);
    end
  end

`ifdef MEM_PHASE_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rstSync) begin
    if (!rstSync) begin
      frameCnt <= '0;
      stallCnt <= '0;
    end else begin
      if (cpuClkEn && (frameCnt != 32'hFFFF_FFFF)) begin
        frameCnt <= frameCnt + 32'd1;
      end
      if (stalled && (stallCnt != 32'hFFFF_FFFF)) begin
        stallCnt <= stallCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_phase_seq.sv
// Bench for mem_phase_seq: two instances (RATIO 4 and 8) against a frame-level model plus literal spot checks.
module tb_mem_phase_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      = 1'b0;
  logic [1:0] weReqA   = 2'b00;
  logic       memRdyA  = 1'b1;
  logic       cpuClkA, cpuClkEnA, stalledA;
  logic [1:0] weOutA;
  logic [1:0] phaseA;
  logic [3:0] weReqB   = 4'hF;
  logic       memRdyB  = 1'b1;
  logic       cpuClkB, cpuClkEnB, stalledB;
  logic [3:0] weOutB;
  logic [2:0] phaseB;
`ifdef MEM_PHASE_SEQ_STATS_EN
  logic [31:0] frameCntA, stallCntA, frameCntB, stallCntB;
`endif

  mem_phase_seq #(.RATIO(4), .NUM_PORTS(2), .WR_PHASE(2)) dutA (
    .clk(clk), .rst(rst), .weReq(weReqA), .memRdy(memRdyA),
    .cpuClk(cpuClkA), .cpuClkEn(cpuClkEnA), .weOut(weOutA), .phase(phaseA), .stalled(stalledA)
`ifdef MEM_PHASE_SEQ_STATS_EN
    , .frameCnt(frameCntA), .stallCnt(stallCntA)
`endif
  );

  mem_phase_seq #(.RATIO(8), .NUM_PORTS(4), .WR_PHASE(6)) dutB (
    .clk(clk), .rst(rst), .weReq(weReqB), .memRdy(memRdyB),
    .cpuClk(cpuClkB), .cpuClkEn(cpuClkEnB), .weOut(weOutB), .phase(phaseB), .stalled(stalledB)
`ifdef MEM_PHASE_SEQ_STATS_EN
    , .frameCnt(frameCntB), .stallCnt(stallCntB)
`endif
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame model: cycles since release, warm-up progress, position in frame, stretched-frame flag.
  int rat[2] = '{4, 8};
  int wrp[2] = '{2, 6};
  int mRel[2], mWarm[2], mPh[2];
  bit mHold[2];

  function automatic bit rdyOf(input int d);
    return (d == 0) ? memRdyA : memRdyB;
  endfunction
  function automatic int reqOf(input int d);
    return (d == 0) ? int'(weReqA) : int'(weReqB);
  endfunction
  function automatic bit running(input int d);
    return (mRel[d] == 2) && (mWarm[d] == rat[d]);
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        mRel[d] = 0; mWarm[d] = 0; mPh[d] = 0; mHold[d] = 1'b0;
      end else if (mRel[d] < 2) begin
        mRel[d]++;
      end else if (mWarm[d] < rat[d]) begin
        mWarm[d]++;
      end else if (mHold[d] || mPh[d] == rat[d] - 1) begin
        if (rdyOf(d)) begin mHold[d] = 1'b0; mPh[d] = 0; end
        else mHold[d] = 1'b1;
      end else begin
        mPh[d]++;
      end
    end
  end

  function automatic int actPhase(input int d); return (d == 0) ? int'(phaseA)    : int'(phaseB);    endfunction
  function automatic int actClk(input int d);   return (d == 0) ? int'(cpuClkA)   : int'(cpuClkB);   endfunction
  function automatic int actEn(input int d);    return (d == 0) ? int'(cpuClkEnA) : int'(cpuClkEnB); endfunction
  function automatic int actSt(input int d);    return (d == 0) ? int'(stalledA)  : int'(stalledB);  endfunction
  function automatic int actWe(input int d);    return (d == 0) ? int'(weOutA)    : int'(weOutB);    endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic bit    run = running(d);
      automatic int    ePh = run ? mPh[d] : 0;
      automatic int    eWe = (run && !mHold[d] && mPh[d] == wrp[d]) ? reqOf(d) : 0;
      automatic string p   = (d == 0) ? "A" : "B";
      check({p, "_phase"},    actPhase(d), ePh);
      check({p, "_cpuClk"},   actClk(d),   (ePh < rat[d] / 2) ? 1 : 0);
      check({p, "_cpuClkEn"}, actEn(d),    (run && mPh[d] == rat[d] - 1 && rdyOf(d)) ? 1 : 0);
      check({p, "_stalled"},  actSt(d),    (run && mHold[d]) ? 1 : 0);
      check({p, "_weOut"},    actWe(d),    eWe);
    end
  end

  // Event tallies for the literal expectations.
  int enCntA = 0, stallCycA = 0, weCnt0A = 0, weCnt1A = 0, weLastPhA = -1;
  int relCyc = 0;
  int wePosB[$];
  logic [7:0] clkPatB = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) relCyc = 0;
    else relCyc++;
  end

  always @(negedge clk) begin
    if (cpuClkEnA) enCntA++;
    if (stalledA) stallCycA++;
    if (weOutA[0]) begin weCnt0A++; weLastPhA = int'(phaseA); end
    if (weOutA[1]) weCnt1A++;
    if (!rst) wePosB.delete();
    else if (weOutB != 4'h0) wePosB.push_back(relCyc);
    if (rst && relCyc >= 10 && relCyc <= 17) clkPatB = {clkPatB[6:0], cpuClkB};
  end

  task automatic waitPhaseA(input int p);
    int found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk); #1;
      if (running(0) && !mHold[0] && mPh[0] == p) found = 1;
    end
    if (found == 0) check("waitPhaseA_timeout", 0, 1);
  endtask

  task automatic waitEnCount(input int base, input int n);
    int found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk); #1;
      if (enCntA - base >= n) found = 1;
    end
    if (found == 0) check("waitEn_timeout", enCntA - base, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b0, b1, s, e;
    logic [3:0] pat;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_phase", phaseA, 0);
    check("rst_cpuClk", cpuClkA, 1);
    check("rst_cpuClkEn", cpuClkEnA, 0);
    check("rst_weOut", weOutA, 0);
    check("rst_stalled", stalledA, 0);

    // Release: 2 sync cycles + 4 warm-up + 3 phases puts the first enable at cycle 9.
    @(posedge clk); #1 rst = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k == 0; i++) begin
      @(negedge clk);
      if (cpuClkEnA) k = relCyc;
    end
    check("first_en_cycle", k, 9);
    pat = '0;
    repeat (4) begin @(negedge clk); pat = {pat[2:0], cpuClkA}; end
    check("cpuClk_pattern", int'(pat), 4'b1100);
    check("second_en", cpuClkEnA, 1);

    // One frame of weReq=01: a single port-0 strobe at phase 2.
    b0 = weCnt0A; b1 = weCnt1A;
    @(posedge clk); #1 weReqA = 2'b01;
    repeat (4) @(posedge clk);
    #1 weReqA = 2'b00;
    check("we0_pulses", weCnt0A - b0, 1);
    check("we0_phase", weLastPhA, 2);
    check("we1_pulses", weCnt1A - b1, 0);

    // Request raised after the write phase and dropped before the next one: no strobe.
    b0 = weCnt0A; b1 = weCnt1A;
    waitPhaseA(2);
    @(posedge clk); #1 weReqA = 2'b11;
    @(posedge clk);
    @(posedge clk); #1 weReqA = 2'b00;
    check("late_req_we0", weCnt0A - b0, 0);
    check("late_req_we1", weCnt1A - b1, 0);

    // memRdy low in phases 0..2 is ignored.
    waitPhaseA(3);
    s = stallCycA;
    @(posedge clk); #1 memRdyA = 1'b0;
    repeat (3) @(posedge clk);
    #1 memRdyA = 1'b1;
    @(negedge clk); #1;
    check("ignored_rdy_stall", stallCycA - s, 0);
    check("ignored_rdy_en", cpuClkEnA, 1);

    // Five cycles of memRdy=0 from phase 3: five HOLD cycles, enable on the sixth.
    waitPhaseA(2);
    s = stallCycA; e = enCntA;
    @(posedge clk); #1 memRdyA = 1'b0;
    repeat (5) @(posedge clk);
    #1 memRdyA = 1'b1;
    @(negedge clk); #1;
    check("stall_cycles", stallCycA - s, 5);
    check("stall_en_pulse", enCntA - e, 1);
    check("stall_phase_frozen", phaseA, 3);
    @(negedge clk); #1;
    check("after_stall_phase", phaseA, 0);
    check("after_stall_stalled", stalledA, 0);

    // Mixed traffic with irregular readiness.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      weReqA  = 2'((i * 3) >> 2);
      memRdyA = ((i % 7) != 3) && ((i % 7) != 4);
    end
    @(posedge clk); #1 memRdyA = 1'b1; weReqA = 2'b00;
    repeat (6) @(posedge clk);

    // Reset during the write phase kills the strobe in the same cycle.
    waitPhaseA(1);
    @(posedge clk); #1 weReqA = 2'b11;
    @(negedge clk); #1;
    check("we_before_rst", weOutA, 3);
    rst = 1'b0; #1;
    check("midrst_weOut", weOutA, 0);
    check("midrst_cpuClkEn", cpuClkEnA, 0);
    check("midrst_phase", phaseA, 0);
    check("midrst_cpuClk", cpuClkA, 1);
    check("midrst_stalled", stalledA, 0);
    check("midrst_weOutB", weOutB, 0);
`ifdef MEM_PHASE_SEQ_STATS_EN
    check("midrst_frameCnt", frameCntA, 0);
    check("midrst_stallCnt", stallCntA, 0);
`endif
    weReqA = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Ten frames with one three-cycle stall.
    e = 0; s = stallCycA;
    e = enCntA;
    waitEnCount(e, 4);
    waitPhaseA(2);
    @(posedge clk); #1 memRdyA = 1'b0;
    repeat (3) @(posedge clk);
    #1 memRdyA = 1'b1;
    waitEnCount(e, 10);
    @(negedge clk); #1;
    check("ten_frames_en", enCntA - e, 10);
    check("ten_frames_stall", stallCycA - s, 3);
`ifdef MEM_PHASE_SEQ_STATS_EN
    check("frameCnt", frameCntA, 10);
    check("stallCnt", stallCntA, 3);
`endif

    // RATIO=8 instance: strobes at phase 6 (cycles 16, 24), cpuClk high for phases 0..3.
    check("B_strobe_count_ge2", (wePosB.size() >= 2) ? 1 : 0, 1);
    if (wePosB.size() >= 2) begin
      check("B_first_strobe", wePosB[0], 16);
      check("B_second_strobe", wePosB[1], 24);
    end
    check("B_cpuClk_pattern", int'(clkPatB), 8'hF0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
